// File: rtl/mult_share_ctrl.sv
// Round-robin front end that time-shares one combinational 32x32 multiplier
// among NUM_REQ requesters and returns each 64-bit product over valid/ready.
module mult_share_ctrl #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MUL_LAT  = 1,
    parameter bit          USE_DONE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [32*NUM_REQ-1:0]      req_a,
    input  logic [32*NUM_REQ-1:0]      req_b,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic                       resp_ready,
    output logic [63:0]                resp_result,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       busy,
    output logic [31:0]                mul_in0,
    output logic [31:0]                mul_in1,
    input  logic [63:0]                mul_result,
    input  logic                       mul_done
);
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] cnt;
    logic [31:0]   op_a, op_b;
    logic [63:0]   res;
    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    int unsigned   cand;
    logic          calc_exit;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr) + i) % NUM_REQ;
            if (!grant_vld && req_valid[IW'(cand)]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(cand);
            end
        end
    end

    assign calc_exit = (state == CALC) && (cnt == CNT_LAST) && (!USE_DONE || mul_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        req_ready  = '0;
        resp_valid = '0;
        unique case (state)
            IDLE: begin
                // rst gates the accept so outputs are quiet while reset is held.
                if (grant_vld && rst) begin
                    req_ready[grant_idx] = 1'b1;
                end
                if (grant_vld) begin
                    state_n = CALC;
                end
            end
            CALC: begin
                if (calc_exit) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                resp_valid[resp_id] = 1'b1;
                if (resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            resp_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_a    <= req_a[32*grant_idx +: 32];
                        op_b    <= req_b[32*grant_idx +: 32];
                        resp_id <= grant_idx;
                        rr_ptr  <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    // Saturates so a late mul_done still sees cnt at its last value.
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (calc_exit) begin
                        res <= mul_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign mul_in0     = op_a;
    assign mul_in1     = op_b;
    assign resp_result = res;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: transaction-level reference model on a default
// instance plus directed mul_done handling on a USE_DONE instance.
module tb_mult_share_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    a_req_valid, a_req_ready, a_resp_valid;
    logic [32*N-1:0] a_req_a, a_req_b;
    logic            a_resp_ready, a_busy, a_mul_done;
    logic [63:0]     a_resp_result, a_mul_result;
    logic [1:0]      a_resp_id;
    logic [31:0]     a_mul_in0, a_mul_in1;

    logic [N-1:0]    b_req_valid, b_req_ready, b_resp_valid;
    logic [32*N-1:0] b_req_a, b_req_b;
    logic            b_resp_ready, b_busy, b_mul_done;
    logic [63:0]     b_resp_result, b_mul_result;
    logic [1:0]      b_resp_id;
    logic [31:0]     b_mul_in0, b_mul_in1;

    assign a_mul_result = 64'(a_mul_in0) * 64'(a_mul_in1);
    assign b_mul_result = 64'(b_mul_in0) * 64'(b_mul_in1);

    mult_share_ctrl #(.NUM_REQ(N), .MUL_LAT(1), .USE_DONE(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_a(a_req_a), .req_b(a_req_b),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_result(a_resp_result), .resp_id(a_resp_id), .busy(a_busy),
        .mul_in0(a_mul_in0), .mul_in1(a_mul_in1),
        .mul_result(a_mul_result), .mul_done(a_mul_done)
    );

    mult_share_ctrl #(.NUM_REQ(N), .MUL_LAT(2), .USE_DONE(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_a(b_req_a), .req_b(b_req_b),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_result(b_resp_result), .resp_id(b_resp_id), .busy(b_busy),
        .mul_in0(b_mul_in0), .mul_in1(b_mul_in1),
        .mul_result(b_mul_result), .mul_done(b_mul_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: one operation at a time, MUL_LAT=1 calc cycles,
    // then a response held until accepted.
    int          m_ptr  = 0;
    int          m_left = 0;
    int          m_id   = 0;
    bit          m_resp = 1'b0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    logic [63:0] m_res  = '0;

    function automatic bit m_idle();
        return !m_resp && (m_left == 0);
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_left = 0; m_id = 0; m_resp = 1'b0;
        m_a = '0; m_b = '0; m_res = '0;
    endtask

    // One clock cycle of instance A: called at posedge+1 with inputs driven.
    task automatic step();
        int g;
        int c;
        logic [N-1:0] eg;
        @(negedge clk);
        g  = -1;
        eg = '0;
        if (m_idle()) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && a_req_valid[c]) g = c;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        check("req_ready", 64'(a_req_ready), 64'(eg));
        check("busy", 64'(a_busy), 64'(!m_idle()));
        check("resp_valid", 64'(a_resp_valid), m_resp ? 64'(4'b0001 << m_id) : 64'd0);
        if (m_resp) begin
            check("resp_result", a_resp_result, m_res);
            check("resp_id", 64'(a_resp_id), 64'(m_id));
        end
        check("mul_in0", 64'(a_mul_in0), 64'(m_a));
        check("mul_in1", 64'(a_mul_in1), 64'(m_b));
        if (m_idle() && g >= 0) begin
            m_a    = a_req_a[32*g +: 32];
            m_b    = a_req_b[32*g +: 32];
            m_id   = g;
            m_ptr  = (g + 1) % N;
            m_left = 1;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_res  = {32'd0, m_a} * {32'd0, m_b};
                m_resp = 1'b1;
            end
        end else if (m_resp && a_resp_ready) begin
            m_resp = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        a_req_a[32*i +: 32] = a;
        a_req_b[32*i +: 32] = b;
    endtask

    task automatic drain();
        a_req_valid  = '0;
        a_resp_ready = 1'b1;
        for (int k = 0; k < 8 && !m_idle(); k++) step();
        check("drain_idle", 64'(m_idle()), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_req_valid = '0; a_req_a = '0; a_req_b = '0; a_resp_ready = 1'b0; a_mul_done = 1'b0;
        b_req_valid = '0; b_req_a = '0; b_req_b = '0; b_resp_ready = 1'b0; b_mul_done = 1'b0;

        #12;
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_resp_valid", 64'(a_resp_valid), 64'd0);
        check("rst_result", a_resp_result, 64'd0);
        check("rst_resp_id", 64'(a_resp_id), 64'd0);
        check("rst_mul_in0", 64'(a_mul_in0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single request 6*6
        set_op(0, 32'd6, 32'd6);
        a_req_valid  = 4'b0001;
        a_resp_ready = 1'b1;
        step();
        a_req_valid = '0;
        step();
        check("single_valid", 64'(a_resp_valid), 64'h1);
        check("single_result", a_resp_result, 64'd36);
        step();
        step();

        // All requesters contending
        set_op(0, 32'd5, 32'd3);
        set_op(1, 32'd7, 32'd2);
        set_op(2, 32'd4, 32'd4);
        set_op(3, 32'd15, 32'd1);
        a_req_valid = 4'b1111;
        for (int k = 0; k < 15; k++) step();
        drain();

        // Backpressure on the response channel
        set_op(0, 32'd6, 32'd6);
        a_req_valid  = 4'b0001;
        a_resp_ready = 1'b0;
        step();
        a_req_valid = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) step();
        check("bp_result", a_resp_result, 64'd36);
        a_resp_ready = 1'b1;
        step();
        drain();

        // Boundary operands
        set_op(1, 32'd0, 32'd5);
        a_req_valid = 4'b0010;
        step();
        a_req_valid = '0;
        step();
        check("zero_result", a_resp_result, 64'd0);
        drain();
        set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        a_req_valid = 4'b0100;
        step();
        a_req_valid = '0;
        step();
        check("max_result", a_resp_result, 64'hFFFF_FFFE_0000_0001);
        step();

        // Pointer now at 3: only 3 and 0 valid -> 3 then 0
        a_req_valid = 4'b1001;
        step();
        check("wrap_id3", 64'(a_resp_id), 64'd3);
        step();
        step();
        step();
        check("wrap_id0", 64'(a_resp_id), 64'd0);
        drain();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            a_req_valid = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) begin
                a_req_a[32*k +: 32] = (n % 9 == 0) ? 32'hFFFF_FFFF : $urandom;
                a_req_b[32*k +: 32] = (n % 11 == 0) ? 32'd0 : $urandom;
            end
            a_resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset asserted mid-CALC
        set_op(2, 32'd11, 32'd13);
        a_req_valid = 4'b0100;
        step();
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(a_busy), 64'd0);
        check("arst_req_ready", 64'(a_req_ready), 64'd0);
        check("arst_resp_valid", 64'(a_resp_valid), 64'd0);
        check("arst_mul_in0", 64'(a_mul_in0), 64'd0);
        check("arst_result", a_resp_result, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        a_req_valid = '0;
        @(posedge clk);
        #1;
        step();
        step();
        set_op(0, 32'd3, 32'd9);
        a_req_valid = 4'b1111;
        step();
        check("arst_next_id", 64'(a_resp_id), 64'd0);
        for (int k = 0; k < 6; k++) step();
        drain();

        // USE_DONE=1, MUL_LAT=2 instance
        b_req_a[31:0] = 32'd9;
        b_req_b[31:0] = 32'd7;
        b_req_valid   = 4'b0001;
        b_resp_ready  = 1'b1;
        b_mul_done    = 1'b0;
        @(negedge clk);
        check("ud_req_ready", 64'(b_req_ready), 64'h1);
        @(posedge clk);
        #1;
        b_req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ud_hold_valid", 64'(b_resp_valid), 64'd0);
            check("ud_hold_busy", 64'(b_busy), 64'd1);
            @(posedge clk);
            #1;
        end
        b_mul_done = 1'b1;
        @(negedge clk);
        check("ud_pre_valid", 64'(b_resp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("ud_valid", 64'(b_resp_valid), 64'h1);
        check("ud_result", b_resp_result, 64'd63);
        @(posedge clk);
        #1;
        check("ud_idle", 64'(b_busy), 64'd0);

        b_req_a[63:32] = 32'd100000;
        b_req_b[63:32] = 32'd3;
        b_req_valid    = 4'b0010;
        @(posedge clk);
        #1;
        b_req_valid = '0;
        check("ud_lat_c0", 64'(b_resp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("ud_lat_c1", 64'(b_resp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("ud_lat_valid", 64'(b_resp_valid), 64'h2);
        check("ud_lat_result", b_resp_result, 64'd300000);
        check("ud_lat_id", 64'(b_resp_id), 64'd1);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
